// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and defaults for the two-port register-file arbiter
package rf_arb_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int         RF_AW       = 6;
   localparam int         RF_DW       = 16;
   localparam int         DEPTH       = 2 ** RF_AW;
   localparam logic [2:0] EMA_DEFAULT = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: first request at or after ptr_i, wrapping
module rr_arbiter #(
   parameter int N = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   assign any_o = |req_i;

   always_comb begin
      int            cand;
      logic [IW-1:0] cand_idx;
      logic          found;
      gnt_o    = '0;
      idx_o    = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int off = 0; off < N; off++) begin
         cand = int'(ptr_i) + off;
         if (cand >= N) cand = cand - N;
         cand_idx = IW'(cand);
         if (!found && req_i[cand_idx]) begin
            found           = 1'b1;
            gnt_o[cand_idx] = 1'b1;
            idx_o           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/rf_2p_access_arbiter.sv
// rtl/rf_2p_access_arbiter.sv - arbitrates read/write requesters onto a 2-port RF macro, zero-fills after reset
module rf_2p_access_arbiter
   import rf_arb_pkg::*;
#(
   parameter int         AW      = $clog2(DEPTH),
   parameter int         DW      = RF_DW,
   parameter int         NW      = 2,
   parameter int         NR      = 2,
   parameter logic [2:0] EMA_VAL = EMA_DEFAULT,
   parameter int         INIT_EN = 1,
   localparam int        WIW     = (NW > 1) ? $clog2(NW) : 1,
   localparam int        RIW     = (NR > 1) ? $clog2(NR) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NW-1:0]    wr_req,
   input  logic [NW*AW-1:0] wr_addr,
   input  logic [NW*DW-1:0] wr_data,
   output logic [NW-1:0]    wr_gnt,
   input  logic [NR-1:0]    rd_req,
   input  logic [NR*AW-1:0] rd_addr,
   output logic [NR-1:0]    rd_gnt,
   output logic             rd_valid,
   output logic [RIW-1:0]   rd_id,
   output logic [DW-1:0]    rd_data,
   output logic             init_done,
   output logic             rf_cena,
   output logic [AW-1:0]    rf_aa,
   input  logic [DW-1:0]    rf_qa,
   output logic             rf_cenb,
   output logic [AW-1:0]    rf_ab,
   output logic [DW-1:0]    rf_db,
   output logic [2:0]       rf_emaa,
   output logic [2:0]       rf_emab
);

   state_e          state_q;
   logic [AW-1:0]   init_cnt_q;
   logic [WIW-1:0]  wr_ptr_q, wr_ptr_d, wr_idx;
   logic [RIW-1:0]  rd_ptr_q, rd_ptr_d, rd_idx;
   logic [NW-1:0]   wr_gnt_raw;
   logic [NR-1:0]   rd_gnt_raw;
   logic            wr_any, rd_any;
   logic            run, in_init, wr_go, rd_go, collide;
   logic [AW-1:0]   wa_arr [NW];
   logic [DW-1:0]   wd_arr [NW];
   logic [AW-1:0]   ra_arr [NR];
   logic [AW-1:0]   wr_sel_addr, rd_sel_addr;
   logic [DW-1:0]   wr_sel_data;
   logic [AW-1:0]   aa_q, ab_q;
   logic [DW-1:0]   db_q;
   logic            s1_valid_q, rd_valid_q;
   logic [RIW-1:0]  s1_id_q, rd_id_q;
   logic [DW-1:0]   rd_data_q;

   // Macro inputs are combinational so the macro latches in the grant cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
         init_cnt_q <= '0;
      end else if (state_q == ST_INIT) begin
         init_cnt_q <= init_cnt_q + 1'b1;
         if (&init_cnt_q) state_q <= ST_RUN;
      end
   end

   assign run       = !reset && (state_q == ST_RUN);
   assign in_init   = !reset && (state_q == ST_INIT);
   assign init_done = run;

   always_comb begin
      for (int i = 0; i < NW; i++) begin
         wa_arr[i] = wr_addr[i*AW +: AW];
         wd_arr[i] = wr_data[i*DW +: DW];
      end
      for (int i = 0; i < NR; i++) ra_arr[i] = rd_addr[i*AW +: AW];
   end

   rr_arbiter #(.N(NW)) u_wr_arb (
      .req_i (wr_req),
      .ptr_i (wr_ptr_q),
      .gnt_o (wr_gnt_raw),
      .idx_o (wr_idx),
      .any_o (wr_any)
   );

   rr_arbiter #(.N(NR)) u_rd_arb (
      .req_i (rd_req),
      .ptr_i (rd_ptr_q),
      .gnt_o (rd_gnt_raw),
      .idx_o (rd_idx),
      .any_o (rd_any)
   );

   assign wr_sel_addr = wa_arr[wr_idx];
   assign wr_sel_data = wd_arr[wr_idx];
   assign rd_sel_addr = ra_arr[rd_idx];

   // Same-address read yields to the write and retries, so it returns the new data.
   assign wr_go   = run && wr_any;
   assign collide = wr_go && rd_any && (rd_sel_addr == wr_sel_addr);
   assign rd_go   = run && rd_any && !collide;

   assign wr_ptr_d = (int'(wr_idx) == NW - 1) ? '0 : wr_idx + 1'b1;
   assign rd_ptr_d = (int'(rd_idx) == NR - 1) ? '0 : rd_idx + 1'b1;

   assign wr_gnt  = wr_go ? wr_gnt_raw : '0;
   assign rd_gnt  = rd_go ? rd_gnt_raw : '0;
   assign rf_cenb = !(wr_go || in_init);
   assign rf_cena = !rd_go;
   assign rf_emaa = EMA_VAL;
   assign rf_emab = EMA_VAL;

   always_comb begin
      rf_ab = ab_q;
      rf_db = db_q;
      rf_aa = aa_q;
      if (reset) begin
         rf_ab = '0;
         rf_db = '0;
         rf_aa = '0;
      end else begin
         if (in_init) begin
            rf_ab = init_cnt_q;
            rf_db = '0;
         end else if (wr_go) begin
            rf_ab = wr_sel_addr;
            rf_db = wr_sel_data;
         end
         if (rd_go) rf_aa = rd_sel_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         aa_q       <= '0;
         ab_q       <= '0;
         db_q       <= '0;
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_id_q    <= '0;
         rd_data_q  <= '0;
      end else begin
         if (in_init) begin
            ab_q <= init_cnt_q;
            db_q <= '0;
         end else if (wr_go) begin
            wr_ptr_q <= wr_ptr_d;
            ab_q     <= wr_sel_addr;
            db_q     <= wr_sel_data;
         end
         if (rd_go) begin
            rd_ptr_q <= rd_ptr_d;
            aa_q     <= rd_sel_addr;
         end
         s1_valid_q <= rd_go;
         s1_id_q    <= rd_idx;
         rd_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            rd_id_q   <= s1_id_q;
            rd_data_q <= rf_qa;
         end
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_id    = rd_id_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_rf_2p_access_arbiter.sv
// tb/tb_rf_2p_access_arbiter.sv - directed self-checking bench with a behavioural RF macro
module tb_rf_2p_access_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  wr_req, rd_req, wr_gnt, rd_gnt;
   logic [11:0] wr_addr, rd_addr;
   logic [31:0] wr_data;
   logic        rd_valid, init_done, rf_cena, rf_cenb;
   logic [0:0]  rd_id;
   logic [15:0] rd_data, rf_qa, rf_db;
   logic [5:0]  rf_aa, rf_ab;
   logic [2:0]  rf_emaa, rf_emab;
   logic [15:0] mem [64];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   rf_2p_access_arbiter dut (
      .clk (clk), .reset (reset),
      .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data), .wr_gnt (wr_gnt),
      .rd_req (rd_req), .rd_addr (rd_addr), .rd_gnt (rd_gnt),
      .rd_valid (rd_valid), .rd_id (rd_id), .rd_data (rd_data), .init_done (init_done),
      .rf_cena (rf_cena), .rf_aa (rf_aa), .rf_qa (rf_qa),
      .rf_cenb (rf_cenb), .rf_ab (rf_ab), .rf_db (rf_db),
      .rf_emaa (rf_emaa), .rf_emab (rf_emab)
   );

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'hDEAD;
      rf_qa = 16'h0;
   end

   always @(posedge clk) begin
      if (!rf_cenb) mem[rf_ab] <= rf_db;
      if (!rf_cena) rf_qa <= mem[rf_aa];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_wr(input int id, input logic [5:0] a, input logic [15:0] d);
      wr_req[id]          = 1'b1;
      wr_addr[id*6 +: 6]  = a;
      wr_data[id*16 +: 16] = d;
   endtask

   task automatic set_rd(input int id, input logic [5:0] a);
      rd_req[id]         = 1'b1;
      rd_addr[id*6 +: 6] = a;
   endtask

   task automatic do_write(input int id, input logic [5:0] a, input logic [15:0] d);
      @(negedge clk);
      set_wr(id, a, d);
      #1;
      check_eq("wr_gnt", 32'(wr_gnt), 32'(1 << id));
      check_eq("wr_port", 32'({rf_cenb, rf_ab, rf_db}), 32'({1'b0, a, d}));
      @(negedge clk);
      wr_req = '0;
   endtask

   task automatic do_read(input int id, input logic [5:0] a, input logic [15:0] exp);
      logic [0:0] id_b;
      id_b = id[0:0];
      @(negedge clk);
      set_rd(id, a);
      #1;
      check_eq("rd_gnt", 32'(rd_gnt), 32'(1 << id));
      check_eq("rd_port", 32'({rf_cena, rf_aa}), 32'({1'b0, a}));
      @(negedge clk);
      rd_req = '0;
      #1;
      check_eq("rd_valid_n1", 32'(rd_valid), 32'(0));
      @(negedge clk);
      #1;
      check_eq("rd_result", 32'({rd_valid, rd_id, rd_data}), 32'({1'b1, id_b, exp}));
   endtask

   initial begin
      reset = 1'b1;
      wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("reset_macro", 32'({rf_cena, rf_cenb, rf_aa, rf_ab, rf_db}), 32'({1'b1, 1'b1, 6'd0, 6'd0, 16'd0}));
      check_eq("reset_outs", 32'({wr_gnt, rd_gnt, rd_valid, rd_id, rd_data, init_done}), 32'(0));
      check_eq("ema", 32'({rf_emaa, rf_emab}), 32'(0));

      reset = 1'b0;
      for (int k = 0; k < 64; k++) begin
         #1;
         check_eq("init_sweep", 32'({init_done, rf_cenb, rf_cena, rf_ab, rf_db}), 32'({3'b001, k[5:0], 16'h0}));
         @(negedge clk);
      end
      #1;
      check_eq("init_done", 32'({init_done, rf_cenb}), 32'({1'b1, 1'b1}));

      do_read(0, 6'd37, 16'h0000);
      do_write(0, 6'd5, 16'hA5A5);
      do_read(1, 6'd5, 16'hA5A5);

      // write pointer is 1 after requester 0; one write from requester 1 returns it to 0
      do_write(1, 6'd20, 16'h2020);
      @(negedge clk);
      set_wr(0, 6'd10, 16'h0A0A);
      set_wr(1, 6'd11, 16'h0B0B);
      for (int i = 0; i < 4; i++) begin
         #1;
         if (i % 2 == 0)
            check_eq("wr_rr", 32'({wr_gnt, rf_cenb, rf_ab, rf_db}), 32'({2'b01, 1'b0, 6'd10, 16'h0A0A}));
         else
            check_eq("wr_rr", 32'({wr_gnt, rf_cenb, rf_ab, rf_db}), 32'({2'b10, 1'b0, 6'd11, 16'h0B0B}));
         @(negedge clk);
      end
      wr_req = '0;

      @(negedge clk);
      set_wr(0, 6'd9, 16'h1234);
      set_rd(0, 6'd9);
      #1;
      check_eq("coll_hold", 32'({rd_gnt, rf_cena, wr_gnt}), 32'({2'b00, 1'b1, 2'b01}));
      @(negedge clk);
      wr_req = '0;
      #1;
      check_eq("coll_retry", 32'({rd_gnt, rf_cena, rf_aa}), 32'({2'b01, 1'b0, 6'd9}));
      @(negedge clk);
      rd_req = '0;
      @(negedge clk);
      #1;
      check_eq("coll_data", 32'({rd_valid, rd_id, rd_data}), 32'({1'b1, 1'b0, 16'h1234}));

      for (int i = 0; i < 4; i++) do_write(1, 6'(i), 16'(16'h10 + i));
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i < 4) set_rd(0, 6'(i));
         else rd_req = '0;
         #1;
         if (i >= 2 && i < 6)
            check_eq("b2b_read", 32'({rd_valid, rd_id, rd_data}), 32'({1'b1, 1'b0, 16'(16'h10 + i - 2)}));
         else
            check_eq("b2b_idle", 32'(rd_valid), 32'(0));
      end

      // read pointer is 1 after the requester-0 reads
      @(negedge clk);
      set_rd(0, 6'd0);
      set_rd(1, 6'd1);
      #1;
      check_eq("rd_rr0", 32'(rd_gnt), 32'(2'b10));
      @(negedge clk);
      #1;
      check_eq("rd_rr1", 32'(rd_gnt), 32'(2'b01));
      @(negedge clk);
      rd_req = '0;
      #1;
      check_eq("rd_rr_d1", 32'({rd_valid, rd_id, rd_data}), 32'({1'b1, 1'b1, 16'h0011}));
      @(negedge clk);
      #1;
      check_eq("rd_rr_d0", 32'({rd_valid, rd_id, rd_data}), 32'({1'b1, 1'b0, 16'h0010}));

      @(negedge clk);
      set_rd(0, 6'd2);
      #1;
      check_eq("mid_gnt", 32'(rd_gnt), 32'(2'b01));
      @(negedge clk);
      rd_req = '0;
      reset = 1'b1;
      #1;
      check_eq("mid_reset", 32'({init_done, rf_cenb, rf_cena}), 32'({1'b0, 1'b1, 1'b1}));
      @(negedge clk);
      #1;
      check_eq("mid_novalid", 32'(rd_valid), 32'(0));
      reset = 1'b0;
      #1;
      check_eq("reinit0", 32'({init_done, rf_cenb, rf_ab}), 32'({1'b0, 1'b0, 6'd0}));
      @(negedge clk);
      #1;
      check_eq("reinit1", 32'({rd_valid, rf_cenb, rf_ab}), 32'({1'b0, 1'b0, 6'd1}));
      for (int t = 0; t < 100 && !init_done; t++) @(negedge clk);
      #1;
      check_eq("reinit_done", 32'(init_done), 32'(1));
      do_read(0, 6'd5, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
